timer_core_param: RTL and testbench
===================================

Name: timer_core_param

Overview:
- Parametrised mm:ss BCD timer core; successor to the single-instance potato timer.
- Sits between the debounced button layer and the display/sprite memory; drives the digits and the digit-select cursor.
- Adds pause/resume, cancel-with-restore, a parametrised tick rate, a configurable minute ceiling, a configurable count-up limit, and a done-hold state.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1-second tick (>=2)
- MAX_MIN, 59, configurable minute ceiling (1..99)
- UP_LIMIT_SEC, 15, count-up terminal value in seconds (1..MAX_MIN*60+59)
- PRESC_W, 27, prescaler width; must satisfy 2^PRESC_W >= TICK_DIV

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mode  in  1  0 = countdown, 1 = count-up; sampled only in CONFIG
- up, down, left, right  in  1 each  single-cycle button pulses
- pressed  in  1  single-cycle confirm/start/pause-toggle pulse
- cancel  in  1  single-cycle abort pulse
- minute2, minute1, second2, second1  out  4 each  BCD display digits
- select  out  3  cursor: 0 = s1, 1 = s2, 2 = m1, 3 = m2, 4 = confirm
- state_o  out  2  0 = CONFIG, 1 = RUN, 2 = PAUSE, 3 = DONE
- finish  out  1  one-cycle pulse on the first cycle of DONE

Behaviour:
- Reset (async, any time, including mid-RUN): state CONFIG, all digits 0, preset 0, select 0, prescaler 0, finish 0.
- CONFIG, select editing:
  - left: select+1, wrapping 4->0.
  - right: select-1, wrapping 0->4.
  - left and right in the same cycle: no change.
- CONFIG, countdown digit editing:
  - up: increments the selected digit with carry into the higher digits (s1 9->0 carries to s2; s2 5->0 to m1; m1 9->0 to m2).
  - up saturates: if the result would exceed MAX_MIN:59, no change.
  - down: decrements the selected digit if it is >0; no borrow; otherwise no change.
  - up has priority over down.
- CONFIG, count-up mode: digits are forced to 00:00 every cycle.
- CONFIG exits:
  - Countdown: pressed with select==4 -> RUN; the current digits are copied into the preset register.
  - Count-up: pressed at any select -> RUN.
  - Countdown start with value 00:00 -> DONE on the next edge (finish pulses).
- Prescaler:
  - Cleared on the CONFIG->RUN transition.
  - Counts only in RUN; frozen in PAUSE.
  - Tick when prescaler==TICK_DIV-1; prescaler then wraps to 0.
  - First tick occurs TICK_DIV cycles after entering RUN.
- Countdown, on tick: BCD decrement with borrow. The tick that reaches 00:00 also moves state to DONE on the same edge.
- Count-up, on tick: BCD increment with carry. The tick that reaches UP_LIMIT_SEC (mm*60+ss) moves state to DONE on the same edge.
- RUN/PAUSE controls:
  - pressed in RUN -> PAUSE; pressed in PAUSE -> RUN. Digits and prescaler are held while paused.
  - cancel in RUN or PAUSE -> CONFIG; digits reload from preset (countdown) or 00:00 (count-up); select=0.
  - cancel beats pressed in the same cycle.
  - A tick coinciding with pressed/cancel is discarded.
- DONE:
  - Digits hold the terminal value; finish=1 only in the first DONE cycle.
  - pressed or cancel -> CONFIG with digits reloaded as for cancel.
- Buttons are ignored in any state where they are not listed above.
- Digit outputs are registered; latency of 1 cycle from button pulse or tick to the new digit value.

Decomposition:
- Shared package timer_pkg: state encodings (CONFIG/RUN/PAUSE/DONE), select encodings, BCD limit constants (9, 5).
- One sub-module: bcd_mmss_step. Combinational ±1 step over four BCD digits with carry/borrow, a saturation flag against MAX_MIN:59, and a terminal flag. Shared by the edit and run paths.

Test Plan (TICK_DIV=4, MAX_MIN=59, UP_LIMIT_SEC=15):
- Edit carry: reset, select 0, set 00:09, then up -> 00:10. Then select 3, up x5 -> 50:10; up x1 more -> 50:10 unchanged (saturates at 59:59 ceiling).
- Countdown: set 00:02, left x4 (select 4), pressed.
  - RUN; at cycle 4 -> 00:01; at cycle 8 -> 00:00, state 3, finish high exactly 1 cycle.
  - pressed -> CONFIG with 00:02.
- Pause: countdown from 01:00. pressed at cycle 2 of RUN -> PAUSE.
  - Wait 20 cycles; digits stay 01:00.
  - pressed again; first tick arrives 2 cycles later -> 00:59.
- Count-up: mode=1, pressed.
  - After 15 ticks (60 cycles), digits 00:15, DONE, finish pulses once.
  - No further increment after 100 more cycles.
- Cancel: countdown from 00:30; after 3 ticks (00:27), cancel -> CONFIG, digits 00:30, select 0. cancel+pressed in the same cycle -> CONFIG, not PAUSE.
- Async reset: assert rst mid-RUN, between clock edges -> digits 00:00, state 0, finish 0 immediately without a clock edge.

Source files
------------

// File: rtl/timer_core_param_pkg.sv
// Shared encodings and BCD helpers for the parametrised mm:ss timer core.
// Imported by the step sub-module, the core and the bench.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] SEL_S1      = 3'd0;
  localparam logic [2:0] SEL_CONFIRM = 3'd4;

  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  // Only the seconds-tens digit rolls over at 5; minute digits roll over at 9.
  function automatic logic [3:0] digit_limit(input int idx);
    return (idx == 1) ? BCD_TENS_MAX : BCD_UNITS_MAX;
  endfunction

  function automatic logic [6:0] bcd_minutes(input logic [15:0] d);
    return 7'(d[15:12]) * 7'd10 + 7'(d[11:8]);
  endfunction

  function automatic logic [13:0] bcd_seconds(input logic [15:0] d);
    return 14'(bcd_minutes(d)) * 14'd60 + 14'(d[7:4]) * 14'd10 + 14'(d[3:0]);
  endfunction

endpackage

// File: rtl/timer_core_param_if.sv
// Button/display bundle between the button layer (master) and the timer core (slave).
interface timer_core_param_if;
  logic       mode;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       pressed;
  logic       cancel;
  logic [3:0] minute2;
  logic [3:0] minute1;
  logic [3:0] second2;
  logic [3:0] second1;
  logic [2:0] select;
  logic [1:0] state_o;
  logic       finish;

  modport master (
    output mode, up, down, left, right, pressed, cancel,
    input  minute2, minute1, second2, second1, select, state_o, finish
  );

  modport slave (
    input  mode, up, down, left, right, pressed, cancel,
    output minute2, minute1, second2, second1, select, state_o, finish
  );
endinterface

// File: rtl/timer_core_param_step.sv
// Combinational +/-1 step over {m2,m1,s2,s1} BCD digits, starting at digit i_pos,
// with a ceiling-saturation flag for the increment and terminal flags for both paths.
module bcd_mmss_step
  import timer_pkg::*;
#(
  parameter int MAX_MIN      = 59,
  parameter int UP_LIMIT_SEC = 15
) (
  input  logic [15:0] i_digits,
  input  logic [1:0]  i_pos,
  output logic [15:0] o_inc,
  output logic        o_incSat,
  output logic        o_incAtLimit,
  output logic [15:0] o_dec,
  output logic        o_decZero
);

  logic       w_carry;
  logic       w_borrow;
  logic [3:0] w_digit;
  logic [3:0] w_limit;

  // Digits below i_pos are untouched; carry/borrow ripple upward from i_pos.
  always_comb begin
    o_inc    = i_digits;
    o_dec    = i_digits;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    w_digit  = 4'd0;
    w_limit  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_digit = i_digits[4*i +: 4];
      w_limit = digit_limit(i);
      if (i >= int'(i_pos)) begin
        if (w_carry) begin
          if (w_digit >= w_limit) begin
            o_inc[4*i +: 4] = 4'd0;
          end else begin
            o_inc[4*i +: 4] = w_digit + 4'd1;
            w_carry = 1'b0;
          end
        end
        if (w_borrow) begin
          if (w_digit == 4'd0) begin
            o_dec[4*i +: 4] = w_limit;
          end else begin
            o_dec[4*i +: 4] = w_digit - 4'd1;
            w_borrow = 1'b0;
          end
        end
      end
    end
    // A carry out of m2 means the value left the two-digit minute range entirely.
    o_incSat     = w_carry || (bcd_minutes(o_inc) > 7'(MAX_MIN));
    o_incAtLimit = (bcd_seconds(o_inc) == 14'(UP_LIMIT_SEC));
    o_decZero    = (o_dec == 16'h0000);
  end

endmodule

// File: rtl/timer_core_param.sv
// mm:ss BCD timer core: digit editing in CONFIG, countdown/count-up in RUN,
// pause/resume, cancel-with-restore and a one-cycle finish pulse on entering DONE.
module timer_core_param
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 100_000_000,
  parameter int MAX_MIN      = 59,
  parameter int UP_LIMIT_SEC = 15,
  parameter int PRESC_W      = 27
) (
  input  logic               clk,
  input  logic               rst,
  timer_core_param_if.slave  bus
);

  state_t             r_state;
  logic [15:0]        r_digits;
  logic [15:0]        r_preset;
  logic [2:0]         r_select;
  logic [PRESC_W-1:0] r_presc;
  logic               r_mode;
  logic               r_finish;

  logic               w_editSel;
  logic [1:0]         w_pos;
  logic               w_selZero;
  logic               w_tick;
  logic [PRESC_W-1:0] w_prescNext;
  logic [15:0]        w_reload;
  logic [15:0]        w_inc;
  logic [15:0]        w_dec;
  logic               w_incSat;
  logic               w_incAtLimit;
  logic               w_decZero;

  // The step unit works on the cursor digit while editing and on s1 while running.
  assign w_editSel   = (r_state == ST_CONFIG) && (r_select != SEL_CONFIRM);
  assign w_pos       = w_editSel ? r_select[1:0] : 2'd0;
  assign w_selZero   = (r_digits[{w_pos, 2'b00} +: 4] == 4'd0);
  assign w_tick      = (r_presc == PRESC_W'(TICK_DIV - 1));
  assign w_prescNext = w_tick ? '0 : r_presc + PRESC_W'(1);
  assign w_reload    = r_mode ? 16'h0000 : r_preset;

  bcd_mmss_step #(
    .MAX_MIN      (MAX_MIN),
    .UP_LIMIT_SEC (UP_LIMIT_SEC)
  ) u_step (
    .i_digits     (r_digits),
    .i_pos        (w_pos),
    .o_inc        (w_inc),
    .o_incSat     (w_incSat),
    .o_incAtLimit (w_incAtLimit),
    .o_dec        (w_dec),
    .o_decZero    (w_decZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_CONFIG;
      r_digits <= '0;
      r_preset <= '0;
      r_select <= SEL_S1;
      r_presc  <= '0;
      r_mode   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        ST_CONFIG: begin
          if (bus.left && !bus.right) begin
            r_select <= (r_select == SEL_CONFIRM) ? SEL_S1 : r_select + 3'd1;
          end else if (bus.right && !bus.left) begin
            r_select <= (r_select == SEL_S1) ? SEL_CONFIRM : r_select - 3'd1;
          end
          if (bus.mode) begin
            r_digits <= '0;
            if (bus.pressed) begin
              r_mode  <= 1'b1;
              r_presc <= '0;
              r_state <= ST_RUN;
            end
          end else if (bus.pressed && (r_select == SEL_CONFIRM)) begin
            r_mode   <= 1'b0;
            r_preset <= r_digits;
            r_presc  <= '0;
            if (r_digits == 16'h0000) begin
              r_state  <= ST_DONE;
              r_finish <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end else if (w_editSel) begin
            if (bus.up) begin
              if (!w_incSat) r_digits <= w_inc;
            end else if (bus.down && !w_selZero) begin
              r_digits <= w_dec;
            end
          end
        end
        // The prescaler keeps counting on a pause/cancel edge; only the digit step is dropped.
        ST_RUN: begin
          r_presc <= w_prescNext;
          if (bus.cancel) begin
            r_state  <= ST_CONFIG;
            r_digits <= w_reload;
            r_select <= SEL_S1;
          end else if (bus.pressed) begin
            r_state <= ST_PAUSE;
          end else if (w_tick) begin
            r_digits <= r_mode ? w_inc : w_dec;
            if (r_mode ? w_incAtLimit : w_decZero) begin
              r_state  <= ST_DONE;
              r_finish <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.cancel) begin
            r_state  <= ST_CONFIG;
            r_digits <= w_reload;
            r_select <= SEL_S1;
          end else if (bus.pressed) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (bus.pressed || bus.cancel) begin
            r_state  <= ST_CONFIG;
            r_digits <= w_reload;
            r_select <= SEL_S1;
          end
        end
        default: r_state <= ST_CONFIG;
      endcase
    end
  end

  assign bus.minute2 = r_digits[15:12];
  assign bus.minute1 = r_digits[11:8];
  assign bus.second2 = r_digits[7:4];
  assign bus.second1 = r_digits[3:0];
  assign bus.select  = r_select;
  assign bus.state_o = r_state;
  assign bus.finish  = r_finish;

endmodule

// File: tb/tb_timer_core_param.sv
// Bench for timer_core_param: a seconds-valued behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_timer_core_param;
  import timer_pkg::*;

  localparam int TICK_DIV     = 4;
  localparam int MAX_MIN      = 59;
  localparam int UP_LIMIT_SEC = 15;
  localparam int PRESC_W      = 3;

  logic clk;
  logic rst;
  timer_core_param_if busIf();

  timer_core_param #(
    .TICK_DIV     (TICK_DIV),
    .MAX_MIN      (MAX_MIN),
    .UP_LIMIT_SEC (UP_LIMIT_SEC),
    .PRESC_W      (PRESC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  int checks = 0;
  int failures = 0;

  // Model: the displayed value is held as a plain count of seconds.
  int mState, mSecs, mSel, mPreset, mMode, mRunCycles, mFinish;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int weightOf(input int sel);
    case (sel)
      0: return 1;
      1: return 10;
      2: return 60;
      default: return 600;
    endcase
  endfunction

  function automatic int digitOf(input int secs, input int sel);
    case (sel)
      0: return secs % 10;
      1: return (secs % 60) / 10;
      2: return (secs / 60) % 10;
      default: return secs / 600;
    endcase
  endfunction

  function automatic int toBcd(input int secs);
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    return ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
  endfunction

  function automatic int digitsNow();
    return int'({busIf.minute2, busIf.minute1, busIf.second2, busIf.second1});
  endfunction

  function automatic logic rb(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic checkVal(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic modelReset();
    mState = 0; mSecs = 0; mSel = 0; mPreset = 0; mMode = 0; mRunCycles = 0; mFinish = 0;
  endtask

  task automatic modelRestore();
    mState = 0;
    mSecs  = mMode ? 0 : mPreset;
    mSel   = 0;
  endtask

  task automatic modelStep();
    int oldSel;
    int doneNow;
    oldSel  = mSel;
    doneNow = 0;
    case (mState)
      0: begin
        if (busIf.left && !busIf.right) mSel = (mSel + 1) % 5;
        else if (busIf.right && !busIf.left) mSel = (mSel + 4) % 5;
        if (busIf.mode) begin
          mSecs = 0;
          if (busIf.pressed) begin
            mMode = 1; mState = 1; mRunCycles = 0;
          end
        end else if (busIf.pressed && oldSel == 4) begin
          mMode = 0; mPreset = mSecs; mRunCycles = 0;
          if (mSecs == 0) begin
            mState = 3; doneNow = 1;
          end else begin
            mState = 1;
          end
        end else if (oldSel < 4) begin
          if (busIf.up) begin
            if (mSecs + weightOf(oldSel) <= MAX_MIN * 60 + 59) mSecs += weightOf(oldSel);
          end else if (busIf.down && digitOf(mSecs, oldSel) != 0) begin
            mSecs -= weightOf(oldSel);
          end
        end
      end
      1: begin
        mRunCycles++;
        if (busIf.cancel) modelRestore();
        else if (busIf.pressed) mState = 2;
        else if (mRunCycles % TICK_DIV == 0) begin
          mSecs += mMode ? 1 : -1;
          if (mSecs == (mMode ? UP_LIMIT_SEC : 0)) begin
            mState = 3; doneNow = 1;
          end
        end
      end
      2: begin
        if (busIf.cancel) modelRestore();
        else if (busIf.pressed) mState = 1;
      end
      3: begin
        if (busIf.pressed || busIf.cancel) modelRestore();
      end
      default: ;
    endcase
    mFinish = doneNow;
  endtask

  // One call is one clock cycle; on return the model and DUT both reflect that edge.
  task automatic applyStimulus(input logic u, input logic d, input logic l,
                               input logic r, input logic p, input logic c);
    @(negedge clk);
    busIf.up = u; busIf.down = d; busIf.left = l;
    busIf.right = r; busIf.pressed = p; busIf.cancel = c;
    @(posedge clk);
    #1 modelStep();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput();
    checkVal("cyc_digits", digitsNow(), toBcd(mSecs));
    checkVal("cyc_state", int'(busIf.state_o), mState);
    checkVal("cyc_select", int'(busIf.select), mSel);
    checkVal("cyc_finish", int'(busIf.finish), mFinish);
  endtask

  task automatic doReset();
    @(negedge clk);
    busIf.up = 0; busIf.down = 0; busIf.left = 0;
    busIf.right = 0; busIf.pressed = 0; busIf.cancel = 0;
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkVal("async_rst_digits", digitsNow(), 0);
    checkVal("async_rst_state", int'(busIf.state_o), 0);
    checkVal("async_rst_select", int'(busIf.select), 0);
    checkVal("async_rst_finish", int'(busIf.finish), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 modelStep();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) checkOutput();
    end
  end

  initial begin
    rst = 1'b1;
    busIf.mode = 0; busIf.up = 0; busIf.down = 0; busIf.left = 0;
    busIf.right = 0; busIf.pressed = 0; busIf.cancel = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkVal("reset_digits", digitsNow(), 0);
    checkVal("reset_state", int'(busIf.state_o), 0);
    checkVal("reset_select", int'(busIf.select), 0);
    checkVal("reset_finish", int'(busIf.finish), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 modelStep();

    $display("[TB] edit carry and saturation");
    repeat (9) applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("edit_0009", digitsNow(), 16'h0009);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("edit_carry_0010", digitsNow(), 16'h0010);
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0);
    checkVal("edit_select_m2", int'(busIf.select), 3);
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("edit_5010", digitsNow(), 16'h5010);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("edit_saturate", digitsNow(), 16'h5010);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkVal("edit_left_right_same", int'(busIf.select), 3);

    $display("[TB] countdown from 00:02");
    doReset();
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("cd_run", int'(busIf.state_o), 1);
    idle(3);
    checkVal("cd_before_tick", digitsNow(), 16'h0002);
    idle(1);
    checkVal("cd_tick1", digitsNow(), 16'h0001);
    idle(4);
    checkVal("cd_zero", digitsNow(), 16'h0000);
    checkVal("cd_done", int'(busIf.state_o), 3);
    checkVal("cd_finish_hi", int'(busIf.finish), 1);
    idle(1);
    checkVal("cd_finish_lo", int'(busIf.finish), 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("cd_back_config", int'(busIf.state_o), 0);
    checkVal("cd_restore", digitsNow(), 16'h0002);

    $display("[TB] pause from 01:00");
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("pause_set_0100", digitsNow(), 16'h0100);
    repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("pause_state", int'(busIf.state_o), 2);
    idle(20);
    checkVal("pause_hold", digitsNow(), 16'h0100);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("pause_resume", int'(busIf.state_o), 1);
    idle(1);
    checkVal("pause_pre_tick", digitsNow(), 16'h0100);
    idle(1);
    checkVal("pause_tick_0059", digitsNow(), 16'h0059);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkVal("pause_cancel_restore", digitsNow(), 16'h0100);

    $display("[TB] count-up to limit");
    busIf.mode = 1;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("up_run", int'(busIf.state_o), 1);
    idle(59);
    checkVal("up_0014", digitsNow(), 16'h0014);
    idle(1);
    checkVal("up_0015", digitsNow(), 16'h0015);
    checkVal("up_done", int'(busIf.state_o), 3);
    checkVal("up_finish", int'(busIf.finish), 1);
    idle(100);
    checkVal("up_hold", digitsNow(), 16'h0015);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("up_back_zero", digitsNow(), 16'h0000);
    busIf.mode = 0;

    $display("[TB] cancel from 00:30");
    applyStimulus(0, 0, 1, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(12);
    checkVal("cancel_0027", digitsNow(), 16'h0027);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkVal("cancel_state", int'(busIf.state_o), 0);
    checkVal("cancel_restore", digitsNow(), 16'h0030);
    checkVal("cancel_select", int'(busIf.select), 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkVal("cancel_beats_pressed", int'(busIf.state_o), 0);

    $display("[TB] async reset mid-run");
    repeat (4) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(4);
    checkVal("rst_pre_0029", digitsNow(), 16'h0029);
    doReset();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 2500; k++) begin
      if (rb(2)) busIf.mode = ~busIf.mode;
      applyStimulus(rb(12), rb(6), rb(6), rb(6), rb(4), rb(2));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
